// File: rtl/replay_merge.sv
// replay_merge: merges masked per-block replay requests into a replay/backoff/retry/abort sequencer.
// Define REPLAY_MERGE_STATS_EN to enable the saturating io_replay_total counter; otherwise it is tied to 0.
module replay_merge #(
  parameter int NUM_BLOCKS = 3,
  parameter logic [NUM_BLOCKS-1:0] REPLAY_MASK = '1,
  parameter int MODE = 0,
  parameter int MAX_RETRY = 7,
  parameter int CNT_W = 4,
  parameter int BACKOFF = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_valid,
  input  logic [NUM_BLOCKS-1:0] io_replay_req,
  output logic                  io_ready,
  output logic                  io_replay,
  output logic                  io_done,
  output logic                  io_abort,
  output logic [CNT_W-1:0]      io_retry_cnt,
  output logic [15:0]           io_replay_total
);
  localparam int BO_W = BACKOFF > 2 ? $clog2(BACKOFF) : 1;
  typedef enum logic [2:0] {S_IDLE, S_REPLAY, S_BACKOFF, S_RETRY, S_ABORT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BO_W-1:0] bo_q, bo_d;
  logic done_q, done_d;
  logic [NUM_BLOCKS-1:0] masked;
  logic hit;
  assign masked = io_replay_req & REPLAY_MASK;
  assign hit = io_valid & (MODE == 0 ? &masked : |masked);
  assign io_ready = state_q == S_IDLE || state_q == S_RETRY;
  assign io_replay = state_q == S_REPLAY;
  assign io_abort = state_q == S_ABORT;
  assign io_done = done_q;
  assign io_retry_cnt = cnt_q;
  // The count is always 0 in IDLE, so IDLE and RETRY share one acceptance rule.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bo_d = bo_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE, S_RETRY: if (io_valid) begin
        if (!hit) begin
          state_d = S_IDLE;
          cnt_d = '0;
          done_d = 1'b1;
        end else if (cnt_q < CNT_W'(MAX_RETRY)) begin
          state_d = S_REPLAY;
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d = S_ABORT;
          cnt_d = '0;
        end
      end
      S_REPLAY: begin
        state_d = BACKOFF > 0 ? S_BACKOFF : S_RETRY;
        bo_d = BO_W'(BACKOFF > 0 ? BACKOFF - 1 : 0);
      end
      S_BACKOFF: begin
        bo_d = bo_q - 1'b1;
        state_d = bo_q == '0 ? S_RETRY : S_BACKOFF;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bo_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bo_q <= bo_d;
      done_q <= done_d;
    end
  end
`ifdef REPLAY_MERGE_STATS_EN
  logic [15:0] total_q, total_d;
  always_comb total_d = io_replay && total_q != 16'hFFFF ? total_q + 16'd1 : total_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) total_q <= '0;
    else total_q <= total_d;
  end
  assign io_replay_total = total_q;
`else
  assign io_replay_total = '0;
`endif
endmodule

// File: tb/tb_replay_merge.sv
// tb_replay_merge: three replay_merge instances (default, mask 100 AND, mask 100 OR) on shared stimulus,
// checked against a transaction-level model of busy time, retry count and output pulses.
module tb_replay_merge;
  localparam int MAXR = 7;
  localparam int BO = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic io_valid = 1'b0;
  logic [2:0] io_replay_req = '0;
  logic [2:0] rdy, rep, dn, ab;
  logic [3:0] cnt [3];
  logic [15:0] tot [3];
  int total = 0;
  int bad = 0;
  int m_stall [3];
  int m_cnt [3];
  int m_pulse [3];
  int m_tot [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    replay_merge #(.REPLAY_MASK(g == 0 ? 3'b111 : 3'b100), .MODE(g == 2 ? 1 : 0)) dut (
      .clk(clk), .reset(reset), .io_valid(io_valid), .io_replay_req(io_replay_req),
      .io_ready(rdy[g]), .io_replay(rep[g]), .io_done(dn[g]), .io_abort(ab[g]),
      .io_retry_cnt(cnt[g]), .io_replay_total(tot[g]));
  end
  function automatic bit m_hit(int k, logic [2:0] req);
    logic [2:0] mask;
    logic [2:0] m;
    mask = k == 0 ? 3'b111 : 3'b100;
    m = req & mask;
    return k == 2 ? m != 3'b000 : m == 3'b111;
  endfunction
  function automatic logic [23:0] exp_vec(int k);
    return {m_stall[k] == 0, m_pulse[k] == 1, m_pulse[k] == 2, m_pulse[k] == 3, 4'(m_cnt[k]), 16'(m_tot[k])};
  endfunction
  function automatic logic [23:0] obs_vec(int k);
    return {rdy[k], rep[k], dn[k], ab[k], cnt[k], tot[k]};
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_stall[k] = 0;
      m_cnt[k] = 0;
      m_pulse[k] = 0;
      m_tot[k] = 0;
    end
  endtask
  task automatic model_step(logic v, logic [2:0] req);
    for (int k = 0; k < 3; k++) begin
`ifdef REPLAY_MERGE_STATS_EN
      if (m_pulse[k] == 1 && m_tot[k] < 65535) m_tot[k]++;
`endif
      m_pulse[k] = 0;
      if (m_stall[k] > 0) m_stall[k]--;
      else if (v) begin
        if (!m_hit(k, req)) begin
          m_cnt[k] = 0;
          m_pulse[k] = 2;
        end else if (m_cnt[k] < MAXR) begin
          m_cnt[k]++;
          m_pulse[k] = 1;
          m_stall[k] = 1 + BO;
        end else begin
          m_cnt[k] = 0;
          m_pulse[k] = 3;
          m_stall[k] = 1;
        end
      end
    end
  endtask
  task automatic tick(logic v, logic [2:0] req);
    io_valid = v;
    io_replay_req = req;
    @(posedge clk);
    model_step(v, req);
    @(negedge clk);
  endtask
  task automatic test_reset();
    model_reset();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_vec(k) !== 24'h800000) begin
        bad++;
        $display("FAIL reset_state dut%0d got=%h exp=%h", k, obs_vec(k), 24'h800000);
      end
    end
    reset = 1'b1;
    tick(1'b0, 3'b000);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_vec(k) !== exp_vec(k)) begin
        bad++;
        $display("FAIL post_reset_idle dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask
  task automatic test_no_replay();
    tick(1'b1, 3'b011);
    total++;
    if ({dn[0], rep[0], cnt[0]} !== {1'b1, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL no_replay_done got=%b exp=%b", {dn[0], rep[0], cnt[0]}, {1'b1, 1'b0, 4'd0});
    end
    tick(1'b0, 3'b000);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_vec(k) !== exp_vec(k)) begin
        bad++;
        $display("FAIL no_replay_after dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask
  task automatic test_replay_done();
    int nr = 0;
    tick(1'b1, 3'b111);
    total++;
    if ({rep[0], rdy[0], cnt[0]} !== {1'b1, 1'b0, 4'd1}) begin
      bad++;
      $display("FAIL replay_pulse got=%b exp=%b", {rep[0], rdy[0], cnt[0]}, {1'b1, 1'b0, 4'd1});
    end
    for (int i = 0; i < 10 && !rdy[0]; i++) begin
      nr++;
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL replay_busy dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
        end
      end
      tick(1'b1, 3'b111);
    end
    total++;
    if (nr !== 3 || cnt[0] !== 4'd1) begin
      bad++;
      $display("FAIL busy_cycles got=%0d cnt=%0d exp=3 cnt=1", nr, cnt[0]);
    end
    tick(1'b1, 3'b000);
    total++;
    if ({dn[0], cnt[0]} !== {1'b1, 4'd0}) begin
      bad++;
      $display("FAIL retry_done got=%b exp=%b", {dn[0], cnt[0]}, {1'b1, 4'd0});
    end
    tick(1'b0, 3'b000);
  endtask
  task automatic test_abort();
    int reps = 0;
    bit seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      tick(1'b1, 3'b111);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL abort_seq dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
        end
      end
      if (rep[0]) reps++;
      if (ab[0]) seen = 1;
    end
    total++;
    if (reps !== MAXR || !seen || cnt[0] !== 4'd0) begin
      bad++;
      $display("FAIL abort_count got=%0d abort=%0d cnt=%0d exp=%0d abort=1 cnt=0", reps, seen, cnt[0], MAXR);
    end
    tick(1'b0, 3'b000);
    total++;
    if ({rdy[0], ab[0], cnt[0]} !== {1'b1, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL abort_idle got=%b exp=%b", {rdy[0], ab[0], cnt[0]}, {1'b1, 1'b0, 4'd0});
    end
  endtask
  task automatic test_mask_modes();
    tick(1'b1, 3'b111);
    total++;
    if ({rep[1], dn[1], rep[2]} !== 3'b011) begin
      bad++;
      $display("FAIL mask_all_req got=%b exp=%b", {rep[1], dn[1], rep[2]}, 3'b011);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 3'b000);
    tick(1'b1, 3'b011);
    total++;
    if ({rep[2], dn[2], dn[1]} !== 3'b011) begin
      bad++;
      $display("FAIL or_masked_off got=%b exp=%b", {rep[2], dn[2], dn[1]}, 3'b011);
    end
    tick(1'b1, 3'b100);
    total++;
    if ({rep[2], rep[1], rep[0]} !== 3'b100) begin
      bad++;
      $display("FAIL or_bit2 got=%b exp=%b", {rep[2], rep[1], rep[0]}, 3'b100);
    end
    for (int i = 0; i < 3; i++) tick(1'b0, 3'b000);
    tick(1'b1, 3'b000);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_vec(k) !== exp_vec(k)) begin
        bad++;
        $display("FAIL mask_drain dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask
  task automatic test_reset_backoff();
    tick(1'b1, 3'b111);
    tick(1'b0, 3'b000);
    #2 reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_vec(k) !== 24'h800000) begin
        bad++;
        $display("FAIL reset_in_backoff dut%0d got=%h exp=%h", k, obs_vec(k), 24'h800000);
      end
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 3'b000);
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL reset_release dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask
  task automatic test_stats();
    logic [15:0] want;
`ifdef REPLAY_MERGE_STATS_EN
    want = 16'd3;
`else
    want = 16'd0;
`endif
    reset = 1'b0;
    #1 model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick(1'b1, 3'b111);
      for (int i = 0; i < 3; i++) tick(1'b0, 3'b000);
    end
    tick(1'b1, 3'b000);
    tick(1'b0, 3'b000);
    total++;
    if (tot[0] !== want) begin
      bad++;
      $display("FAIL replay_total got=%0d exp=%0d", tot[0], want);
    end
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_vec(k) !== exp_vec(k)) begin
        bad++;
        $display("FAIL stats_model dut%0d got=%h exp=%h", k, obs_vec(k), exp_vec(k));
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      tick($urandom_range(0, 3) != 0, 3'($urandom));
      for (int k = 0; k < 3; k++) begin
        total++;
        if (obs_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL random dut%0d cycle=%0d got=%h exp=%h", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_no_replay();
    test_replay_done();
    test_abort();
    test_mask_modes();
    test_reset_backoff();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/replay_merge.md
REPLAY_MERGE -- requirements
Module: replay_merge

Interface
REQ-001 SHALL provide parameter NUM_BLOCKS, default 3: number of block replay-request channels (1..16).
REQ-002 SHALL provide parameter REPLAY_MASK, default all-ones (NUM_BLOCKS bits): bit i=1 lets channel i contribute; bit i=0 forces channel i's term to 0.
REQ-003 SHALL provide parameter MODE, default 0: 0 = AND-combine masked terms, 1 = OR-combine.
REQ-004 SHALL provide parameter MAX_RETRY, default 7: replays allowed per transaction before abort (1..2^CNT_W-1).
REQ-005 SHALL provide parameter CNT_W, default 4: retry counter width.
REQ-006 SHALL provide parameter BACKOFF, default 2: idle cycles after each replay pulse (0 allowed).
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 io_valid  input  1  transaction present this cycle.
REQ-010 io_replay_req  input  NUM_BLOCKS  per-block replay request, sampled with io_valid.
REQ-011 io_ready  output  1  block accepts io_valid this cycle.
REQ-012 io_replay  output  1  one-cycle replay pulse.
REQ-013 io_done  output  1  one-cycle pulse: transaction completed without replay.
REQ-014 io_abort  output  1  one-cycle pulse: retry limit exceeded.
REQ-015 io_retry_cnt  output  CNT_W  replays issued for current transaction.
REQ-016 io_replay_total  output  16  saturating count of replay pulses (see Configuration).

Function
REQ-017 hit SHALL be io_valid & combine(io_replay_req & REPLAY_MASK), combine per MODE; in MODE 0 any zero mask bit makes hit constantly 0.
REQ-018 States SHALL be IDLE, REPLAY, BACKOFF, RETRY, ABORT; io_ready SHALL be 1 only in IDLE and RETRY (combinational from state).
REQ-019 io_valid and io_replay_req SHALL be ignored when io_ready=0.
REQ-020 IDLE: io_valid & !hit -> stay IDLE, io_done=1 next cycle; hit -> REPLAY, io_retry_cnt<=1.
REQ-021 REPLAY: io_replay=1 for exactly one cycle; then BACKOFF if BACKOFF>0, else RETRY.
REQ-022 BACKOFF: stay exactly BACKOFF cycles, then RETRY.
REQ-023 RETRY: io_valid & !hit -> IDLE, io_retry_cnt<=0, io_done=1 next cycle; hit with io_retry_cnt<MAX_RETRY -> REPLAY, count+1; hit with io_retry_cnt==MAX_RETRY -> ABORT.
REQ-024 ABORT: io_abort=1 for one cycle, io_retry_cnt<=0, then IDLE.
REQ-025 Latency: accepted hit at edge t SHALL give io_replay=1 in cycle t+1; io_done/io_abort are registered pulses.
REQ-026 io_replay, io_done, io_abort SHALL be mutually exclusive in any cycle.
REQ-027 io_retry_cnt SHALL never exceed MAX_RETRY or wrap.
REQ-028 io_valid=0 in IDLE/RETRY SHALL hold state and count.

Reset
REQ-029 reset low SHALL immediately force IDLE, io_replay=0, io_done=0, io_abort=0, io_retry_cnt=0, io_replay_total=0, io_ready=1.
REQ-030 reset asserted mid-REPLAY/BACKOFF/ABORT SHALL discard the transaction with no pulse on release.

Configuration
REQ-031 Macro REPLAY_MERGE_STATS_EN defined: io_replay_total increments on every io_replay pulse, saturating at 16'hFFFF.
REQ-032 Macro undefined: io_replay_total SHALL be tied to 0 and no counter logic generated; other behaviour identical.

Verification (defaults unless stated)
REQ-033 io_valid=1, io_replay_req=3'b011 -> no replay; io_done=1 next cycle, io_retry_cnt=0.
REQ-034 io_valid=1, io_replay_req=3'b111 -> io_replay=1 next cycle, io_ready=0 for 3 cycles, io_retry_cnt=1; then io_valid with req=0 -> io_done, count 0.
REQ-035 Persistent hit -> exactly 7 replay pulses, 8th hit gives io_abort=1 one cycle, count 0, back to IDLE.
REQ-036 REPLAY_MASK=3'b100, MODE=0, req=3'b111 -> never replays; MODE=1, req=3'b011 -> no replay, req=3'b100 -> replay.
REQ-037 reset low during BACKOFF -> outputs zero immediately; after release io_ready=1, no pulse.
REQ-038 With REPLAY_MERGE_STATS_EN, 3 replays -> io_replay_total=3; without macro -> 0.
